// File: rtl/ccc_cfg_pkg.sv
// Shared types for the CCC dynamic-reconfiguration APB initiator.
// Holds the controller state encoding and the CCC APB bus widths.
package ccc_cfg_pkg;

    localparam int CCC_ADDR_W = 6;
    localparam int CCC_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ARST,
        WAIT_LOCK
    } cfg_state_e;

endpackage

// File: rtl/ccc_apb_reconfig_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst_n (async active-low, clears to 0), d (async in), q (synced out).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ccc_apb_reconfig.sv
// APB initiator for the CCC/PLL dynamic-reconfiguration port: single
// register transfers from the fabric, plus a PLL reset/relock commit.
// Ports: PCLK/PRESET_N; req_* / rsp_* request channel; commit and its
// done/err pulses; cfg_busy, locked status; APB master (PSEL..PRDATA,
// BUSY); LOCK (async) in; PLL_ARST_N out.
module ccc_apb_reconfig
    import ccc_cfg_pkg::*;
#(
    parameter int ARST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int TO_W         = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [CCC_ADDR_W-1:0] req_addr,
    input  logic [CCC_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [CCC_DATA_W-1:0] rsp_rdata,
    input  logic                  commit,
    output logic                  commit_done,
    output logic                  commit_err,
    output logic                  cfg_busy,
    output logic                  locked,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [CCC_ADDR_W-1:0] PADDR,
    output logic [CCC_DATA_W-1:0] PWDATA,
    input  logic [CCC_DATA_W-1:0] PRDATA,
    input  logic                  BUSY,
    input  logic                  LOCK,
    output logic                  PLL_ARST_N
);

    localparam logic [TO_W-1:0] ARST_LAST = TO_W'(ARST_CYCLES - 1);
    localparam logic [TO_W-1:0] LOCK_LAST = TO_W'(LOCK_TIMEOUT - 1);

    cfg_state_e            state_q, state_d;
    logic [TO_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                  pend_q, pend_d;
    logic [CCC_ADDR_W-1:0] paddr_q, paddr_d;
    logic [CCC_DATA_W-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [CCC_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  arst_n_q, arst_n_d;

    sync_2ff u_lock_sync (
        .clk   (PCLK),
        .rst_n (PRESET_N),
        .d     (LOCK),
        .q     (locked)
    );

    // commit in the same cycle as a request wins, so it blocks acceptance
    assign req_ready = (state_q == IDLE) && !BUSY && !pend_q && !commit;

    // shared ARST / WAIT_LOCK counter, saturating at all-ones
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ((pend_q || commit) && !BUSY) begin
                    state_d = ARST;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    if (commit) pend_d = 1'b1;
                    if (req_valid && req_ready) begin
                        paddr_d  = req_addr;
                        pwdata_d = req_wdata;
                        pwrite_d = req_write;
                        state_d  = SETUP;
                    end
                end
            end
            SETUP: begin
                if (commit) pend_d = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (commit) pend_d = 1'b1;
                // no PREADY on the CCC: ACCESS is always one cycle
                if (!pwrite_q) rsp_rdata_d = PRDATA;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            ARST: begin
                if (cnt_q == ARST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_LOCK: begin
                if (locked) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == LOCK_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // registered so the PLL reset never sees decode glitches
        arst_n_d = (state_d != ARST);
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            arst_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            arst_n_q    <= arst_n_d;
        end
    end

    assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE     = (state_q == ACCESS);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PLL_ARST_N  = arst_n_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign commit_done = done_q;
    assign commit_err  = err_q;
    assign cfg_busy    = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_ccc_apb_reconfig.sv
// Directed bench for ccc_apb_reconfig (LOCK_TIMEOUT reduced to 100).
// Inputs change and outputs are sampled on the falling edge of PCLK.
module tb_ccc_apb_reconfig;

    logic       PCLK;
    logic       PRESET_N;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       commit;
    logic       commit_done;
    logic       commit_err;
    logic       cfg_busy;
    logic       locked;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       BUSY;
    logic       LOCK;
    logic       PLL_ARST_N;

    int n_checks;
    int n_errors;
    int n;
    logic saw;

    ccc_apb_reconfig #(
        .ARST_CYCLES  (16),
        .LOCK_TIMEOUT (100),
        .TO_W         (16)
    ) dut (
        .PCLK        (PCLK),
        .PRESET_N    (PRESET_N),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .commit      (commit),
        .commit_done (commit_done),
        .commit_err  (commit_err),
        .cfg_busy    (cfg_busy),
        .locked      (locked),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .BUSY        (BUSY),
        .LOCK        (LOCK),
        .PLL_ARST_N  (PLL_ARST_N)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        PRESET_N  = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        commit    = 1'b0;
        PRDATA    = '0;
        BUSY      = 1'b0;
        LOCK      = 1'b1;

        // reset values with LOCK already high
        repeat (3) @(negedge PCLK);
        chk("rst_ctl", {PSEL, PENABLE, PWRITE}, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
        chk("rst_done_err", {commit_done, commit_err}, 0);
        chk("rst_arst_n", PLL_ARST_N, 1);
        chk("rst_locked", locked, 0);
        chk("rst_busy", cfg_busy, 0);
        PRESET_N = 1'b1;
        @(negedge PCLK);
        chk("lock_sync1", locked, 0);
        @(negedge PCLK);
        chk("lock_sync2", locked, 1);
        chk("idle_ready", req_ready, 1);

        // write 0x05 <- 0xA5
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 6'h05;
        req_wdata = 8'hA5;
        #1 chk("wr_ready", req_ready, 1);
        @(negedge PCLK);
        req_valid = 1'b0;
        chk("wr_setup", {PSEL, PENABLE}, 2'b10);
        @(negedge PCLK);
        chk("wr_access", {PSEL, PENABLE, PWRITE}, 3'b111);
        chk("wr_paddr", PADDR, 6'h05);
        chk("wr_pwdata", PWDATA, 8'hA5);
        chk("wr_rsp_early", rsp_valid, 0);
        @(negedge PCLK);
        chk("wr_rsp", {rsp_valid, rsp_rdata}, {1'b1, 8'h00});
        chk("wr_psel_off", {PSEL, PENABLE}, 0);
        @(negedge PCLK);
        chk("wr_rsp_pulse", rsp_valid, 0);
        chk("wr_hold", {PWRITE, PADDR, PWDATA}, {1'b1, 6'h05, 8'hA5});

        // read 0x12, PRDATA valid only during ACCESS
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 6'h12;
        PRDATA    = 8'hEE;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        PRDATA = 8'h3C;
        chk("rd_access", {PSEL, PENABLE, PWRITE}, 3'b110);
        chk("rd_paddr", PADDR, 6'h12);
        @(negedge PCLK);
        PRDATA = 8'hEE;
        chk("rd_rsp", {rsp_valid, rsp_rdata}, {1'b1, 8'h3C});

        // BUSY holds off acceptance for 5 cycles
        BUSY      = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 6'h21;
        req_wdata = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("busy_ready", req_ready, 0);
            chk("busy_psel", PSEL, 0);
            @(negedge PCLK);
        end
        BUSY = 1'b0;
        #1 chk("busy_release", req_ready, 1);
        @(negedge PCLK);
        req_valid = 1'b0;
        chk("busy_setup", {PSEL, PENABLE}, 2'b10);
        @(negedge PCLK);
        chk("busy_access", {PADDR, PWDATA}, {6'h21, 8'h5A});
        @(negedge PCLK);
        chk("busy_rsp", {rsp_valid, rsp_rdata}, {1'b1, 8'h3C});

        // commit, LOCK drops at ARST start and returns later
        commit = 1'b1;
        @(negedge PCLK);
        commit = 1'b0;
        LOCK   = 1'b0;
        chk("c_cfg_busy", cfg_busy, 1);
        n = 0;
        while (!PLL_ARST_N && n < 100) begin
            n++;
            @(negedge PCLK);
        end
        chk("c_arst_len", n, 16);
        repeat (10) @(negedge PCLK);
        chk("c_unlocked", locked, 0);
        LOCK = 1'b1;
        n    = 0;
        saw  = 1'b0;
        while (!commit_done && n < 20) begin
            @(negedge PCLK);
            n++;
            if (commit_err) saw = 1'b1;
        end
        chk("c_done_lat", (n >= 2 && n <= 3), 1);
        chk("c_no_err", saw, 0);
        @(negedge PCLK);
        chk("c_after", {cfg_busy, commit_done, locked}, 3'b001);

        // LOCK stuck low: timeout
        LOCK = 1'b0;
        repeat (3) @(negedge PCLK);
        commit = 1'b1;
        @(negedge PCLK);
        commit = 1'b0;
        n = 0;
        while (!PLL_ARST_N && n < 100) begin
            n++;
            @(negedge PCLK);
        end
        chk("t_arst_len", n, 16);
        n   = 0;
        saw = 1'b0;
        while (!commit_err && n < 300) begin
            @(negedge PCLK);
            n++;
            if (commit_done) saw = 1'b1;
        end
        chk("t_err_lat", n, 100);
        chk("t_no_done", saw, 0);
        @(negedge PCLK);
        chk("t_after", {cfg_busy, commit_err}, 0);

        // commit and request together: ARST first, then the transfer
        commit    = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 6'h07;
        req_wdata = 8'h11;
        #1 chk("cr_ready", req_ready, 0);
        @(negedge PCLK);
        commit = 1'b0;
        chk("cr_arst_first", {PLL_ARST_N, PSEL}, 2'b00);
        n   = 0;
        saw = 1'b0;
        while (!PSEL && n < 300) begin
            @(negedge PCLK);
            n++;
            if (commit_err) saw = 1'b1;
        end
        req_valid = 1'b0;
        chk("cr_lat", n, 117);
        chk("cr_err_before", saw, 1);
        @(negedge PCLK);
        chk("cr_access", {PENABLE, PADDR, PWDATA}, {1'b1, 6'h07, 8'h11});
        @(negedge PCLK);
        chk("cr_rsp", rsp_valid, 1);

        // reset in the middle of ARST
        commit = 1'b1;
        @(negedge PCLK);
        commit = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("mr_arst_low", PLL_ARST_N, 0);
        PRESET_N = 1'b0;
        #1;
        chk("mr_arst_n", PLL_ARST_N, 1);
        chk("mr_idle", {cfg_busy, PSEL, PENABLE}, 0);
        @(negedge PCLK);
        PRESET_N = 1'b1;
        @(negedge PCLK);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
